// File: rtl/mem_stream_reader.sv
// mem_stream_reader: strided burst reader from async-read memory into a valid/ready stream.
module mem_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int SIZE   = 32,
    parameter int LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_cmd_rdy,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [SIZE-1:0]   i_mem_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [SIZE-1:0]   o_data,
    output logic              o_last,
    output logic              o_done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] stride;
    logic [LEN_W-1:0]  remaining;
    logic              slot_free;

    assign slot_free = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_cmd_rdy  <= 1'b1;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_done     <= 1'b0;
            o_data     <= '0;
            o_mem_addr <= '0;
            stride     <= '0;
            remaining  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && i_len != '0) begin
                        stride     <= i_stride;
                        o_mem_addr <= i_base;
                        remaining  <= i_len;
                        o_cmd_rdy  <= 1'b0;
                        state      <= RUN;
                    end else if (i_start) begin
                        o_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (o_valid && i_ready && o_last) begin
                        o_valid   <= 1'b0;
                        o_last    <= 1'b0;
                        o_done    <= 1'b1;
                        o_cmd_rdy <= 1'b1;
                        state     <= IDLE;
                    end else if (slot_free && remaining != '0) begin
                        // memory is read combinationally, so the word at ptr is captured here
                        o_data     <= i_mem_data;
                        o_valid    <= 1'b1;
                        o_last     <= remaining == LEN_W'(1);
                        o_mem_addr <= o_mem_addr + stride;
                        remaining  <= remaining - 1'b1;
                    end else if (slot_free) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
